pzcorebus_downsizer_response_merger: RTL

//  Merges narrow master-side response beats into wide slave-side responses for the corebus downsizer.

---
 rtl/pzcorebus_downsizer_response_merger_pkg.sv | 34 +++
 rtl/pzcorebus_downsizer_response_merger_fifo.sv | 76 +++++++
 rtl/pzcorebus_downsizer_response_merger.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pzcorebus_downsizer_response_merger_pkg.sv
// ----------------------------------------------------------------------------
// pzcorebus_downsizer_response_merger_pkg
//   Shared corebus definitions used by the downsizer response merger:
//   - pzcorebus_response_type : response kind carried on sresp
//   - get_unit_enable()       : mask of `units` consecutive unit-enable bits
//                               starting at slot `index`. The request path
//                               uses it for the same lane math.
// ----------------------------------------------------------------------------
package pzcorebus_downsizer_response_merger_pkg;

  typedef enum logic [1:0] {
    PZCOREBUS_RESPONSE           = 2'b00,
    PZCOREBUS_RESPONSE_WITH_DATA = 2'b01
  } pzcorebus_response_type;

  localparam int PZCOREBUS_MAX_UNITS = 64;

  function automatic logic [PZCOREBUS_MAX_UNITS-1:0] get_unit_enable(
    input int index,
    input int units
  );
    logic [PZCOREBUS_MAX_UNITS-1:0] mask;
    mask = '0;
    for (int i = 0; i < PZCOREBUS_MAX_UNITS; i++) begin
      if ((i >= (index * units)) && (i < ((index + 1) * units))) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/pzcorebus_downsizer_response_merger_fifo.sv
// ----------------------------------------------------------------------------
// pzcorebus_downsizer_response_merger_fifo
//   Small circular FIFO holding merged wide responses.
//   A push on a full FIFO is taken when the same cycle pops.
// Ports
//   i_clk / i_rst_n : clock, asynchronous active-low reset
//   push_i, data_i  : write request and data
//   pop_i           : remove head entry
//   data_o          : head entry (stable until popped)
//   empty_o, full_o : occupancy flags
//   count_o         : number of stored entries
// ----------------------------------------------------------------------------
module pzcorebus_downsizer_response_merger_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW  = $clog2(DEPTH + 1)
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNTW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q;
  logic [PTRW-1:0]  rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             push_en_s;
  logic             pop_en_s;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] ptr);
    if (ptr == PTRW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTRW'(1);
    end
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNTW'(DEPTH));
  assign pop_en_s  = pop_i && !empty_o;
  assign push_en_s = push_i && (!full_o || pop_en_s);
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_en_s) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push_en_s && !pop_en_s) begin
        count_q <= count_q + CNTW'(1);
      end else if (pop_en_s && !push_en_s) begin
        count_q <= count_q - CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/pzcorebus_downsizer_response_merger.sv
// ----------------------------------------------------------------------------
// pzcorebus_downsizer_response_merger
//   Merges narrow response beats from the downsized (master) side into wide
//   responses for the upstream (slave) side. Ratio 2/4/8, aligned or
//   unit-enable lane placement, optional output FIFO so narrow beats keep
//   draining while the wide side stalls.
// Ports
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   master_*              : narrow response beats in (sresp_* in, mresp_accept out)
//   slave_*               : wide merged responses out (sresp_* out, mresp_accept in)
//   o_merging             : a partial merge is held
//   o_pending             : merged responses queued (0 without FIFO)
// ----------------------------------------------------------------------------
module pzcorebus_downsizer_response_merger
  import pzcorebus_downsizer_response_merger_pkg::*;
#(
  parameter  int MASTER_DATA_WIDTH   = 32,
  parameter  int CONVERSION_RATIO    = 2,
  parameter  int UNIT_WIDTH          = 8,
  parameter  int ID_WIDTH            = 4,
  parameter  int INFO_WIDTH          = 4,
  parameter  bit ALIGNED_ACCESS_ONLY = 1'b0,
  parameter  int OUTPUT_DEPTH        = 2,
  localparam int SLAVE_DATA_WIDTH    = MASTER_DATA_WIDTH * CONVERSION_RATIO,
  localparam int MU                  = MASTER_DATA_WIDTH / UNIT_WIDTH,
  localparam int SU                  = MU * CONVERSION_RATIO,
  localparam int CW                  = $clog2(CONVERSION_RATIO),
  localparam int PW                  = (OUTPUT_DEPTH == 0) ? 1 : $clog2(OUTPUT_DEPTH + 1)
)(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         master_sresp_valid_i,
  output logic                         master_mresp_accept_o,
  input  pzcorebus_response_type       master_sresp_i,
  input  logic [ID_WIDTH-1:0]          master_sid_i,
  input  logic                         master_serror_i,
  input  logic [MASTER_DATA_WIDTH-1:0] master_sdata_i,
  input  logic [INFO_WIDTH-1:0]        master_sinfo_i,
  input  logic [SU-1:0]                master_sresp_uniten_i,
  input  logic                         master_sresp_last_i,
  output logic                         slave_sresp_valid_o,
  input  logic                         slave_mresp_accept_i,
  output pzcorebus_response_type       slave_sresp_o,
  output logic [ID_WIDTH-1:0]          slave_sid_o,
  output logic                         slave_serror_o,
  output logic [SLAVE_DATA_WIDTH-1:0]  slave_sdata_o,
  output logic [INFO_WIDTH-1:0]        slave_sinfo_o,
  output logic [SU-1:0]                slave_sresp_uniten_o,
  output logic                         slave_sresp_last_o,
  output logic                         o_merging,
  output logic [PW-1:0]                o_pending
);

  typedef struct packed {
    pzcorebus_response_type      sresp;
    logic [ID_WIDTH-1:0]         sid;
    logic                        serror;
    logic [SLAVE_DATA_WIDTH-1:0] sdata;
    logic [INFO_WIDTH-1:0]       sinfo;
    logic [SU-1:0]               sresp_uniten;
    logic                        sresp_last;
  } merged_response_t;

  logic [CW-1:0]               beat_cnt_q, beat_cnt_d;
  logic [SLAVE_DATA_WIDTH-1:0] data_q, data_d;
  logic                        error_q, error_d;
  logic [SU-1:0]               uniten_q, uniten_d;
  logic [INFO_WIDTH-1:0]       info_q, info_d;

  logic [SU-1:0]               lane_en_s;
  logic                        ratio_done_s;
  logic                        complete_beat_s;
  logic                        slot_free_s;
  logic                        beat_fire_s;
  logic [SLAVE_DATA_WIDTH-1:0] merged_data_s;
  merged_response_t            merged_s;
  merged_response_t            out_s;

  // Lane selection: aligned mode fills the slot of the current beat count,
  // unaligned mode follows the beat's own unit enables.
  if (ALIGNED_ACCESS_ONLY) begin : g_aligned
    assign lane_en_s    = SU'(get_unit_enable(int'(beat_cnt_q), MU));
    assign ratio_done_s = (beat_cnt_q == CW'(CONVERSION_RATIO - 1));
  end else begin : g_unaligned
    assign lane_en_s    = master_sresp_uniten_i;
    assign ratio_done_s = master_sresp_uniten_i[SU-1];
  end

  // Each wide unit takes the matching narrow unit when enabled, else keeps
  // whatever the merge register already holds.
  for (genvar u = 0; u < SU; u++) begin : g_unit
    assign merged_data_s[u*UNIT_WIDTH +: UNIT_WIDTH] =
      lane_en_s[u] ? master_sdata_i[(u % MU)*UNIT_WIDTH +: UNIT_WIDTH]
                   : data_q[u*UNIT_WIDTH +: UNIT_WIDTH];
  end

  assign complete_beat_s = (master_sresp_i == PZCOREBUS_RESPONSE) ||
                           (master_sresp_last_i != 1'b0) || ratio_done_s;
  assign master_mresp_accept_o = !complete_beat_s || slot_free_s;
  assign beat_fire_s           = master_sresp_valid_i && master_mresp_accept_o;

  assign merged_s.sresp        = master_sresp_i;
  assign merged_s.sid          = master_sid_i;
  assign merged_s.serror       = error_q | master_serror_i;
  assign merged_s.sdata        = merged_data_s;
  assign merged_s.sinfo        = (beat_cnt_q == '0) ? master_sinfo_i : info_q;
  assign merged_s.sresp_uniten = uniten_q | master_sresp_uniten_i;
  assign merged_s.sresp_last   = master_sresp_last_i;

  // Merge state next-value: accumulate on partial beats, clear on completion.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    error_d    = error_q;
    uniten_d   = uniten_q;
    info_d     = info_q;
    if (beat_fire_s) begin
      data_d = merged_data_s;
      info_d = merged_s.sinfo;
      if (complete_beat_s) begin
        beat_cnt_d = '0;
        error_d    = 1'b0;
        uniten_d   = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CW'(1);
        error_d    = merged_s.serror;
        uniten_d   = merged_s.sresp_uniten;
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Merge state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt_q <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
      uniten_q   <= '0;
      info_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      error_q    <= error_d;
      uniten_q   <= uniten_d;
      info_q     <= info_d;
    end
  end

  if (OUTPUT_DEPTH > 0) begin : g_fifo
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;
    merged_response_t head_s;

    assign pop_s       = !empty_s && slave_mresp_accept_i;
    assign slot_free_s = !full_s || pop_s;
    assign push_s      = beat_fire_s && complete_beat_s;

    pzcorebus_downsizer_response_merger_fifo #(
      .WIDTH ($bits(merged_response_t)),
      .DEPTH (OUTPUT_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push_i  (push_s),
      .data_i  (merged_s),
      .pop_i   (pop_s),
      .data_o  (head_s),
      .empty_o (empty_s),
      .full_o  (full_s),
      .count_o (o_pending)
    );

    assign slave_sresp_valid_o = !empty_s;
    assign out_s               = head_s;
  end else begin : g_bypass
    // Without a FIFO the completing beat is forwarded in the same cycle.
    assign slot_free_s         = slave_mresp_accept_i;
    assign slave_sresp_valid_o = master_sresp_valid_i && complete_beat_s;
    assign out_s               = merged_s;
    assign o_pending           = '0;
  end

  assign slave_sresp_o        = out_s.sresp;
  assign slave_sid_o          = out_s.sid;
  assign slave_serror_o       = out_s.serror;
  assign slave_sdata_o        = out_s.sdata;
  assign slave_sinfo_o        = out_s.sinfo;
  assign slave_sresp_uniten_o = out_s.sresp_uniten;
  assign slave_sresp_last_o   = out_s.sresp_last;
  assign o_merging            = (beat_cnt_q != '0);

endmodule
